// File: rtl/ip_sequencer.sv
// Instruction-pointer unit: increment, absolute jump, signed relative branch,
// and a call/return stack with sticky overflow/underflow error flags.
module ip_sequencer #(
  parameter int             W         = 8,
  parameter int             DEPTH     = 4,
  parameter logic [W-1:0]   RESET_VEC = '0,
  localparam int            SPW       = $clog2(DEPTH+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2:0]     op,
  input  logic [W-1:0]   d,
  input  logic           err_clr,
  output logic [W-1:0]   ip,
  output logic [W-1:0]   tos,
  output logic [SPW-1:0] sp,
  output logic           stack_full,
  output logic           stack_empty,
  output logic           err_ovf,
  output logic           err_unf
);

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  // Storage sized to the full sp index range so sp indexes it without resizing;
  // entries at or above DEPTH are never written.
  localparam int             NENT = 1 << SPW;
  localparam logic [SPW-1:0] FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] ONE  = SPW'(1);

  logic [W-1:0] stk [NENT];
  logic [W-1:0] ip_nxt;
  logic         push;

  assign stack_full  = (sp == FULL);
  assign stack_empty = (sp == '0);
  assign ip_nxt      = ip + W'(1);
  assign push        = en && (op == OP_CALL) && !stack_full;

  always_comb begin
    tos = '0;
    if (!stack_empty) tos = stk[sp - ONE];
  end

  // Stack contents are unobservable while sp==0, so they need no reset.
  always_ff @(posedge clk) begin
    if (push) stk[sp] <= ip_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip      <= RESET_VEC;
      sp      <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      // Clear first so an error raised in the same cycle overrides it.
      if (err_clr) begin
        err_ovf <= 1'b0;
        err_unf <= 1'b0;
      end
      if (en) begin
        case (op)
          OP_INC: ip <= ip_nxt;
          OP_JMP: ip <= d;
          // Sign extension followed by truncation to W bits is just a W-bit add.
          OP_BR:  ip <= ip + d;
          OP_CALL: begin
            if (stack_full) err_ovf <= 1'b1;
            else begin
              sp <= sp + ONE;
              ip <= d;
            end
          end
          OP_RET: begin
            if (stack_empty) err_unf <= 1'b1;
            else begin
              sp <= sp - ONE;
              ip <= stk[sp - ONE];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ip_sequencer.sv
// Directed bench for ip_sequencer (W=8, DEPTH=4, RESET_VEC=0xFD).
module tb_ip_sequencer;

  localparam int W = 8;
  localparam int DEPTH = 4;
  localparam int SPW = $clog2(DEPTH+1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [2:0]     op = 3'b000;
  logic [W-1:0]   d = '0;
  logic           err_clr = 1'b0;
  logic [W-1:0]   ip, tos;
  logic [SPW-1:0] sp;
  logic           stack_full, stack_empty, err_ovf, err_unf;

  int checks = 0;
  int errors = 0;

  ip_sequencer #(.W(W), .DEPTH(DEPTH), .RESET_VEC(8'hFD)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .err_clr(err_clr),
    .ip(ip), .tos(tos), .sp(sp), .stack_full(stack_full),
    .stack_empty(stack_empty), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3, RET = 3'd4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic [2:0] o, input logic [W-1:0] dd,
                      input logic clr);
    @(negedge clk);
    en = e; op = o; d = dd; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] eip, input int esp,
                        input logic [7:0] etos);
    check({tag, ".ip"}, 32'(ip), 32'(eip));
    check({tag, ".sp"}, 32'(sp), 32'(esp));
    check({tag, ".tos"}, 32'(tos), 32'(etos));
  endtask

  initial begin
    #12;
    chk_st("rst", 8'hFD, 0, 8'h00);
    check("rst.empty", 32'(stack_empty), 1);
    check("rst.full", 32'(stack_full), 0);
    check("rst.ovf", 32'(err_ovf), 0);
    check("rst.unf", 32'(err_unf), 0);
    @(negedge clk); rst = 1'b0;

    step(1, INC, 8'h00, 0); check("inc1", 32'(ip), 32'hFE);
    step(1, INC, 8'h00, 0); check("inc2", 32'(ip), 32'hFF);
    step(1, INC, 8'h00, 0); check("inc3.wrap", 32'(ip), 32'h00);
    step(1, INC, 8'h00, 0); check("inc4", 32'(ip), 32'h01);
    for (int i = 0; i < 3; i++) begin
      step(0, JMP, 8'hAA, 0); check("hold", 32'(ip), 32'h01);
    end

    step(1, JMP, 8'h40, 0); check("jmp40", 32'(ip), 32'h40);
    step(1, BR, 8'hF0, 0);  check("br.neg", 32'(ip), 32'h30);
    step(1, BR, 8'h7F, 0);  check("br.pos", 32'(ip), 32'hAF);
    step(1, JMP, 8'h12, 0); check("jmp12", 32'(ip), 32'h12);
    step(1, 3'b110, 8'h77, 0); check("nop6", 32'(ip), 32'h12);
    step(1, 3'b111, 8'h77, 0); chk_st("nop7", 8'h12, 0, 8'h00);
    check("nop.errs", 32'({err_ovf, err_unf}), 0);

    step(1, JMP, 8'h10, 0);
    step(1, CALL, 8'h80, 0); chk_st("call1", 8'h80, 1, 8'h11);
    step(1, CALL, 8'hA0, 0); chk_st("call2", 8'hA0, 2, 8'h81);
    step(1, RET, 8'h00, 0);  chk_st("ret1", 8'h81, 1, 8'h11);
    step(1, RET, 8'h00, 0);  chk_st("ret2", 8'h11, 0, 8'h00);
    check("ret2.empty", 32'(stack_empty), 1);

    step(1, CALL, 8'h20, 0);
    step(1, CALL, 8'h30, 0);
    step(1, CALL, 8'h40, 0);
    step(1, CALL, 8'h50, 0); chk_st("fill", 8'h50, 4, 8'h41);
    check("fill.full", 32'(stack_full), 1);
    step(1, CALL, 8'h55, 0); chk_st("ovf", 8'h50, 4, 8'h41);
    check("ovf.flag", 32'(err_ovf), 1);
    step(1, RET, 8'h00, 0);  chk_st("ovf.ret", 8'h41, 3, 8'h31);
    check("ovf.sticky", 32'(err_ovf), 1);
    step(0, RET, 8'h00, 1);  check("clr.en0.ovf", 32'(err_ovf), 0);
    check("clr.en0.ip", 32'(ip), 32'h41);

    step(1, RET, 8'h00, 0);  chk_st("drain1", 8'h31, 2, 8'h21);
    step(1, RET, 8'h00, 0);  chk_st("drain2", 8'h21, 1, 8'h12);
    step(1, RET, 8'h00, 0);  chk_st("drain3", 8'h12, 0, 8'h00);
    step(1, RET, 8'h00, 0);  chk_st("unf", 8'h12, 0, 8'h00);
    check("unf.flag", 32'(err_unf), 1);
    step(1, INC, 8'h00, 1);  check("clr.inc.unf", 32'(err_unf), 0);
    check("clr.inc.ip", 32'(ip), 32'h13);
    step(1, RET, 8'h00, 1);  check("clr.set.unf", 32'(err_unf), 1);
    check("clr.set.ip", 32'(ip), 32'h13);

    step(1, CALL, 8'h60, 0);
    step(1, CALL, 8'h61, 0);
    step(1, CALL, 8'h62, 0);
    step(1, CALL, 8'h63, 0); chk_st("refill", 8'h63, 4, 8'h63);
    step(1, CALL, 8'h99, 0); check("ovf2.flag", 32'({err_ovf, err_unf}), 32'b11);
    step(1, CALL, 8'h99, 1); check("clr.mix", 32'({err_ovf, err_unf}), 32'b10);
    chk_st("clr.mix", 8'h63, 4, 8'h63);
    step(1, RET, 8'h00, 0);  chk_st("pop", 8'h63, 3, 8'h62);

    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1 chk_st("arst", 8'hFD, 0, 8'h00);
    check("arst.empty", 32'(stack_empty), 1);
    check("arst.errs", 32'({err_ovf, err_unf}), 0);
    #1 rst = 1'b0;
    step(1, RET, 8'h00, 0);  chk_st("arst.ret", 8'hFD, 0, 8'h00);
    check("arst.unf", 32'(err_unf), 1);
    step(1, INC, 8'h00, 0);  check("arst.inc", 32'(ip), 32'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_sequencer.md
Name: ip_sequencer

Overview:
Parametrised instruction-pointer unit for the IP segment datapath. It generalises the basic increment-or-load IP register with a configurable width, signed relative branches, and a hardware call/return stack of configurable depth. It also reports sticky overflow and underflow errors. It sits between the control unit, which drives op/en, and the instruction memory address bus, which is driven by ip.

Parameters:
W, 8, width of ip, d and stack entries
DEPTH, 4, number of return-stack entries (>=1)
RESET_VEC, 0, value loaded into ip on reset (W bits)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  1: execute op this cycle; 0: hold all state
op  in  3  000 INC, 001 JMP, 010 BR, 011 CALL, 100 RET, 101-111 reserved (NOP)
d  in  W  absolute target (JMP/CALL) or signed two's-complement offset (BR)
ip  out  W  current instruction pointer, registered
tos  out  W  top-of-stack entry; 0 when stack empty
sp  out  $clog2(DEPTH+1)  number of valid stack entries, 0..DEPTH
stack_full  out  1  sp == DEPTH
stack_empty  out  1  sp == 0
err_ovf  out  1  sticky: CALL attempted while full
err_unf  out  1  sticky: RET attempted while empty
err_clr  in  1  synchronous clear of err_ovf/err_unf

Behaviour:
- Reset (rst=1, asynchronous): ip=RESET_VEC, sp=0, err_ovf=0, err_unf=0. Hence tos=0, stack_empty=1, stack_full=0. Stack storage contents are don't-care after reset, because they cannot be observed while sp=0.
- All registered outputs update 1 cycle after the sampling edge. tos, stack_full and stack_empty are combinational from registered state.
- en=0: ip, sp, stack and error flags hold, whatever op and d are. err_clr still acts.
- en=1, operations are executed as follows:
  - INC: ip <= ip+1, modulo 2^W (0xFF -> 0x00 for W=8).
  - JMP: ip <= d.
  - BR: ip <= ip + sign_extend(d), modulo 2^W. The offset is taken from ip, not from ip+1.
  - CALL, not full: stack[sp] <= ip+1 (mod 2^W), sp <= sp+1, ip <= d.
  - CALL, full: no push, sp unchanged, ip unchanged, err_ovf <= 1.
  - RET, not empty: ip <= stack[sp-1], sp <= sp-1.
  - RET, empty: ip unchanged, sp unchanged, err_unf <= 1.
  - Reserved ops: no state change and no error.
- Stack is LIFO; tos = stack[sp-1] when sp>0.
- err_clr=1 clears both flags on the edge. If a new error event occurs in the same cycle, the set wins for that flag; the other flag still clears.
- Errors never corrupt ip or the stack. The faulting op is a no-op apart from setting its flag.
- rst asserted mid-sequence (e.g. with a non-empty stack) discards the stack immediately. The first op after rst deassertion operates from RESET_VEC with sp=0.
- No X propagation: the result for an out-of-range op is defined (NOP).

Test Plan:
- Reset/INC wrap: reset with RESET_VEC=0xFD, then 4 INC cycles with en=1 -> ip = FE, FF, 00, 01. Hold en=0 for 3 cycles -> ip stays 01.
- JMP/BR: ip=0x40. BR d=0xF0 (-16) -> ip=0x30. BR d=0x7F -> ip=0xAF. JMP d=0x12 -> ip=0x12. op=110 -> ip stays 0x12.
- Nested call/return: from ip=0x10, CALL 0x80, then CALL 0xA0 -> sp=2, tos=0x81, ip=0xA0. RET -> ip=0x81, sp=1, tos=0x11. RET -> ip=0x11, sp=0, stack_empty=1.
- Overflow: 4 CALLs fill the stack (stack_full=1). A 5th CALL d=0x55 -> ip and sp unchanged, err_ovf=1. Then RET returns the 4th pushed address.
- Underflow and clear: with an empty stack, RET -> err_unf=1 and ip unchanged. err_clr with INC -> err_unf=0 and ip+1. err_clr with RET on the empty stack in the same cycle -> err_unf remains 1.
- Async reset mid-operation: sp=3, assert rst between clock edges -> ip=RESET_VEC and sp=0 immediately, without a clock edge. After release, RET -> err_unf=1.
